// File: rtl/lz77_decoder_stream_if.sv
// lz77_decoder_stream_if: token input and character output handshake bundle
// for lz77_decoder_stream. The decoder connects through the slave modport;
// the token source / character sink side uses the master modport.
interface lz77_decoder_stream_if #(
  parameter int WCHAR = 8,
  parameter int WPOS  = 4,
  parameter int WLEN  = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WPOS-1:0]  code_pos;
  logic [WLEN-1:0]  code_len;
  logic [WCHAR-1:0] chardata;
  logic             out_valid;
  logic             out_ready;
  logic [WCHAR-1:0] char_nxt;
  logic             finish;
  logic             err;

  modport master (
    output in_valid, code_pos, code_len, chardata, out_ready,
    input  in_ready, out_valid, char_nxt, finish, err
  );

  modport slave (
    input  in_valid, code_pos, code_len, chardata, out_ready,
    output in_ready, out_valid, char_nxt, finish, err
  );
endinterface

// File: rtl/lz77_decoder_stream.sv
// lz77_decoder_stream: flow-controlled LZ77 token expander.
// Each accepted (pos, len, literal) token yields len characters copied from
// the search buffer followed by the literal, one character per output
// handshake. The end-sign literal moves the block into a terminal DONE state
// with finish asserted until reset.
// Optional feature macro: LZ77_DEC_ERR_EN -- when defined, accepting a token
// whose code_pos lies beyond the search buffer raises a sticky err flag.
module lz77_decoder_stream #(
  parameter int               WSEARCH = 9,
  parameter int               WCHAR   = 8,
  parameter int               WPOS    = 4,
  parameter int               WLEN    = 3,
  parameter logic [WCHAR-1:0] END_SGN = WCHAR'(8'h24)
) (
  input logic                  clk,
  input logic                  reset,
  lz77_decoder_stream_if.slave bus
);

  typedef enum logic [2:0] {IDLE, COPY, LIT, DRAIN, DONE} state_t;

  state_t           state;
  logic [WCHAR-1:0] buf_q [WSEARCH];
  logic [WPOS-1:0]  pos_q;
  logic [WLEN-1:0]  len_q;
  logic [WLEN-1:0]  cnt_q;
  logic [WCHAR-1:0] lit_q;
  logic [WCHAR-1:0] char_p0;
  logic             vld_p0;
  logic             in_ready_q;
  logic             finish_q;
  logic             load;
  logic [WCHAR-1:0] copy_char;
  logic [WCHAR-1:0] load_char;

  // Search buffer read; positions past the buffer depth read as zero.
  always_comb begin
    copy_char = '0;
    for (int i = 0; i < WSEARCH; i++) begin
      if (32'(pos_q) == 32'(i)) copy_char = buf_q[i];
    end
  end

  assign load      = ((state == COPY) || (state == LIT)) && (!vld_p0 || bus.out_ready);
  assign load_char = (state == LIT) ? lit_q : copy_char;

  // Search buffer: every produced character shifts in at position 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WSEARCH; i++) buf_q[i] <= '0;
    end else if (load) begin
      buf_q[0] <= load_char;
      for (int i = 1; i < WSEARCH; i++) buf_q[i] <= buf_q[i-1];
    end
  end

  // Token FSM with registered handshake outputs and output character stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pos_q      <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      lit_q      <= '0;
      char_p0    <= '0;
      vld_p0     <= 1'b0;
      in_ready_q <= 1'b1;
      finish_q   <= 1'b0;
    end else begin
      if (load) begin
        char_p0 <= load_char;
        vld_p0  <= 1'b1;
      end else if (vld_p0 && bus.out_ready) begin
        vld_p0  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            pos_q      <= bus.code_pos;
            len_q      <= bus.code_len;
            lit_q      <= bus.chardata;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state      <= (bus.code_len != '0) ? COPY : LIT;
          end
        end
        COPY: begin
          if (load) begin
            cnt_q <= cnt_q + WLEN'(1);
            if (cnt_q == len_q - WLEN'(1)) state <= LIT;
          end
        end
        LIT: begin
          if (load) begin
            if (lit_q == END_SGN) begin
              state <= DRAIN;
            end else begin
              state      <= IDLE;
              in_ready_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // The end-sign is the only character in flight; wait for its transfer.
          if (vld_p0 && bus.out_ready) begin
            state    <= DONE;
            finish_q <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef LZ77_DEC_ERR_EN
  logic err_q;

  // Sticky flag for tokens that point past the search buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if ((state == IDLE) && bus.in_valid &&
                 (32'(bus.code_pos) >= 32'(WSEARCH))) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = vld_p0;
  assign bus.char_nxt  = char_p0;
  assign bus.finish    = finish_q;

endmodule

// File: tb/tb_lz77_decoder_stream.sv
// tb_lz77_decoder_stream: directed bench for lz77_decoder_stream. Expected
// characters come from a back-reference model over the decoded stream;
// literal sequences pin the model for each scenario.
module tb_lz77_decoder_stream;

  localparam int WS = 9;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  lz77_decoder_stream_if #(.WCHAR(8), .WPOS(4), .WLEN(3)) bus ();

  lz77_decoder_stream #(
    .WSEARCH(WS), .WCHAR(8), .WPOS(4), .WLEN(3), .END_SGN(8'h24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] decoded[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: copy back-references into the decoded stream, limited to the
  // search depth; anything older (or before the stream start) is zero.
  task automatic model_token(input int p, input int l, input logic [7:0] c);
    logic [7:0] ch;
    for (int k = 0; k < l; k++) begin
      ch = (p < WS && p < decoded.size()) ? decoded[decoded.size()-1-p] : 8'h00;
      decoded.push_back(ch);
      exp_q.push_back(ch);
    end
    decoded.push_back(c);
    exp_q.push_back(c);
  endtask

  // Compare every completed output transfer against the model.
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.char_nxt);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL stream_char: got unexpected %0h, expected none at %0t", bus.char_nxt, $time);
      end else begin
        chk("stream_char", bus.char_nxt, exp_q.pop_front());
      end
    end
  end

  task automatic send_token(input int p, input int l, input logic [7:0] c);
    int n = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.code_pos = 4'(p);
    bus.code_len = 3'(l);
    bus.chardata = c;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL token_accept: got in_ready 0 after %0d cycles, expected 1", n);
    end else begin
      model_token(p, l, c);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_seq(input string name, input logic [7:0] e[$]);
    chk({name, "_len"}, got_q.size(), e.size());
    for (int i = 0; i < e.size() && i < got_q.size(); i++) chk(name, got_q[i], e[i]);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    decoded.delete();
    got_q.delete();
    @(posedge clk); #3;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e[$];
    logic [7:0] c0;
    int n;

    bus.in_valid  = 1'b0;
    bus.code_pos  = '0;
    bus.code_len  = '0;
    bus.chardata  = '0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_char_nxt", bus.char_nxt, 0);
    chk("rst_finish", bus.finish, 0);
    chk("rst_err", bus.err, 0);
    #2 reset = 1'b1;

    // Literal-only token, then an overlapping copy
    send_token(0, 0, 8'h41);
    @(negedge clk);
    chk("lat_pre_valid", bus.out_valid, 0);
    chk("lat_busy_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("lat_first_valid", bus.out_valid, 1);
    chk("lat_first_char", bus.char_nxt, 8'h41);
    send_token(0, 3, 8'h42);
    @(negedge clk);
    chk("copy_in_ready", bus.in_ready, 0);
    wait_drain("drain1");
    e = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h42};
    check_seq("seq_AAAAB", e);

    // Copy from deeper in the buffer
    got_q.delete();
    send_token(3, 2, 8'h43);
    wait_drain("drain2");
    e = '{8'h41, 8'h41, 8'h43};
    check_seq("seq_AAC", e);

    // Back-pressure mid-copy
    do_reset();
    send_token(0, 0, 8'h41);
    send_token(0, 3, 8'h42);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    c0 = bus.char_nxt;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_char", bus.char_nxt, c0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain("drain_stall");
    e = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h42};
    check_seq("seq_stall", e);

    // End-sign handling
    do_reset();
    send_token(0, 0, 8'h41);
    send_token(0, 0, 8'h42);
    send_token(1, 0, 8'h24);
    n = 0;
    while (!(bus.out_valid && bus.char_nxt == 8'h24) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("end_char_seen", bus.char_nxt, 8'h24);
    chk("finish_early", bus.finish, 0);
    @(posedge clk); #1;
    chk("finish_set", bus.finish, 1);
    chk("done_in_ready", bus.in_ready, 0);
    chk("done_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b1;
    bus.code_pos = 4'd0;
    bus.code_len = 3'd0;
    bus.chardata = 8'h51;
    repeat (5) begin
      @(negedge clk);
      chk("done_ignore_valid", bus.out_valid, 0);
      chk("done_hold_finish", bus.finish, 1);
    end
    bus.in_valid = 1'b0;
    chk("end_queue_empty", exp_q.size(), 0);
    e = '{8'h41, 8'h42, 8'h24};
    check_seq("seq_end", e);

    // Asynchronous reset while a copy character is pending
    do_reset();
    send_token(0, 0, 8'h41);
    send_token(0, 3, 8'h42);
    @(posedge clk); #1;
    chk("pre_rst_valid", bus.out_valid, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_finish", bus.finish, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    decoded.delete();
    got_q.delete();
    @(posedge clk); #3;
    reset = 1'b1;
    send_token(2, 1, 8'h58);
    wait_drain("drain_rst");
    e = '{8'h00, 8'h58};
    check_seq("seq_0X", e);

    // Position beyond the search buffer
    got_q.delete();
    chk("err_pre", bus.err, 0);
    send_token(12, 1, 8'h5A);
    @(negedge clk);
`ifdef LZ77_DEC_ERR_EN
    chk("err_set", bus.err, 1);
`else
    chk("err_tied", bus.err, 0);
`endif
    wait_drain("drain_err");
    e = '{8'h00, 8'h5A};
    check_seq("seq_0Z", e);
`ifdef LZ77_DEC_ERR_EN
    chk("err_sticky", bus.err, 1);
`else
    chk("err_still0", bus.err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lz77_decoder_stream.md
Name: lz77_decoder_stream

Overview:
- Parametrised, flow-controlled successor to the fixed 9-char LZ77 decoder.
- Accepts one (pos, len, literal) token per handshake and expands it into len copied characters followed by the literal.
- Each decoded character leaves through a valid/ready output port with full back-pressure.
- Sits between the token source (file reader or encoder loopback) and the character sink; asserts finish after the end-sign literal.

Parameters:
- WSEARCH, 9: search buffer depth in characters.
- WCHAR, 8: character width in bits.
- WPOS, 4: code_pos width; needs 2**WPOS >= WSEARCH.
- WLEN, 3: code_len width; max copy run is 2**WLEN-1.
- END_SGN, 8'h24: literal value that terminates the stream ('$'). Width is WCHAR.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  token valid.
- in_ready  out  1  block can accept a token.
- code_pos  in  WPOS  copy source index; 0 = most recent character.
- code_len  in  WLEN  number of copied characters before the literal.
- chardata  in  WCHAR  literal character.
- out_valid  out  1  char_nxt valid.
- out_ready  in  1  sink accepts char_nxt.
- char_nxt  out  WCHAR  decoded character.
- finish  out  1  end-sign literal has been delivered.
- err  out  1  sticky out-of-range position flag; see Optional Feature.

Behaviour:
- Reset (reset low, asynchronous): search buffer all 0, state IDLE, in_ready=1, out_valid=0, char_nxt=0, finish=0, err=0, all counters 0.
- Reset mid-token or with out_valid high: the pending token and output character are discarded. Decoding resumes from IDLE with a zeroed buffer.
- The search buffer is a shift register buf[0..WSEARCH-1]. On every char load it shifts buf[i+1]<=buf[i] and buf[0]<=loaded char.
- load = (state==COPY or LIT) and (!out_valid or out_ready). A load places the char in char_nxt, sets out_valid=1 and shifts the buffer in the same edge.
- If out_valid and out_ready and no load occurs, out_valid clears.
- If out_valid and !out_ready: char_nxt, out_valid, the buffer and counters hold.
- State machine:
  - IDLE: in_ready=1. On in_valid, latch pos_q/len_q/lit_q, set cnt=0, go to COPY if code_len!=0, else LIT.
  - COPY: in_ready=0. On load, char = buf[pos_q] and cnt++. When cnt==len_q-1 at the load, go to LIT.
  - LIT: in_ready=0. On load, char = lit_q. If lit_q==END_SGN go to DRAIN, else go to IDLE.
  - DRAIN: waits for the end-sign transfer (out_valid and out_ready), then goes to DONE.
  - DONE: in_ready=0, out_valid=0, finish=1, held until reset.
- pos_q is sampled once per token. Because the buffer shifts each copy, overlapping copies (pos < len) repeat the pattern, as in classic LZ77.
- Latency: token accepted at edge E0; first char valid after E0+1; with out_ready=1, one char per cycle. A token yields len+1 chars in len+1 cycles, plus one IDLE cycle before the next token.
- Copied characters equal to END_SGN never set finish; only the literal does.
- Position arithmetic is unsigned and has no wrap. pos_q >= WSEARCH reads as 0.

Optional Feature:
- Macro: LZ77_DEC_ERR_EN.
- Defined: accepting a token with code_pos >= WSEARCH sets err=1. err is sticky until reset, and decoding still proceeds with 0 copied.
- Undefined: err is tied 0 and there is no comparison logic.

Test Plan:
- Reset, then tokens (0,0,'A') and (0,3,'B') with out_ready=1 -> char_nxt sequence 'A','A','A','A','B'; each valid for exactly one cycle; in_ready low during expansion.
- Next token (3,2,'C') -> 'A','A','C' (buf after 'B' is B,A,A,A,...).
- Back-pressure: hold out_ready=0 for 3 cycles mid-COPY -> char_nxt stable, out_valid=1, and no extra chars after out_ready returns. The sequence is identical to the unstalled run.
- End: token (1,0,'$') after 'A','B' -> char_nxt='$'. finish=1 the cycle after its transfer; in_ready=0 and out_valid=0 thereafter; further in_valid is ignored.
- Reset pulse low while in COPY with out_valid=1 -> out_valid=0, finish=0, in_ready=1 immediately. Next token (2,1,'X') outputs 0,'X' (buffer cleared).
- With LZ77_DEC_ERR_EN and WSEARCH=9: token (12,1,'Z') -> outputs 0,'Z', and err rises after acceptance and stays 1. Without the macro, err stays 0.
